// File: rtl/bpred_ctrl.sv
// ---------------------------------------------------------------------------
// bpred_ctrl
//
// Branch-prediction controller around a table of 2-bit saturating counters.
// Fetch issues lookups; the registered prediction appears one cycle later.
// Every accepted lookup is remembered in an in-order queue as {idx, pred}.
// Execute resolves the oldest outstanding prediction, which trains the
// counter that produced it and raises a one-cycle mispredict pulse.
//
// Optional feature macro: BPRED_BYPASS_EN
//   defined   : a lookup that hits the index being updated in the same cycle
//               sees the post-update counter value.
//   undefined : such a lookup sees the pre-update value (read-before-write).
//
// Parameters:
//   IDX_W  table index width (2**IDX_W counters)
//   DEPTH  max outstanding predictions (power of two, >= 2)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   lookup request
//   req_idx     counter index for the lookup
//   req_ready   lookup can be accepted this cycle
//   pred_valid  registered: a lookup was accepted on the last edge
//   pred_taken  registered predicted direction (holds when no accept)
//   res_valid   resolution of the oldest outstanding prediction
//   res_taken   actual branch direction
//   mispredict  registered one-cycle pulse: resolved dir != stored pred
//   inflight    number of outstanding predictions
//
// Handshake: a lookup transfers on a rising edge where req_valid && req_ready.
// req_ready comes only from the registered count, so it never depends on
// res_valid in the same cycle. res_valid has no ready; it is consumed when
// inflight > 0 and silently dropped otherwise.
// ---------------------------------------------------------------------------
module bpred_ctrl #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [IDX_W-1:0]           req_idx,
    output logic                       req_ready,
    output logic                       pred_valid,
    output logic                       pred_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     inflight
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [1:0]       ctr    [ENTRIES];
    logic [IDX_W-1:0] q_idx  [DEPTH];
    logic             q_pred [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_pred;
    logic [1:0]       head_ctr;
    logic [1:0]       upd_ctr;
    logic [1:0]       look_ctr;

    assign req_ready = (count < CNT_W'(DEPTH));
    assign inflight  = count;
    assign accept    = req_valid && req_ready;
    assign pop       = res_valid && (count != '0);
    assign head_idx  = q_idx[rd_ptr];
    assign head_pred = q_pred[rd_ptr];
    assign head_ctr  = ctr[head_idx];

    // Saturating train of the counter that produced the head prediction.
    always_comb begin
        upd_ctr = head_ctr;
        if (res_taken) begin
            if (head_ctr != 2'b11) upd_ctr = head_ctr + 2'b01;
        end else begin
            if (head_ctr != 2'b00) upd_ctr = head_ctr - 2'b01;
        end
    end

    // Lookup read; the bypass build forwards a same-cycle update.
    always_comb begin
        look_ctr = ctr[req_idx];
`ifdef BPRED_BYPASS_EN
        if (pop && (head_idx == req_idx)) look_ctr = upd_ctr;
`endif
    end

    // Counter table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b11;
        end else if (pop) begin
            ctr[head_idx] <= upd_ctr;
        end
    end

    // Queue payload needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_idx[wr_ptr]  <= req_idx;
            q_pred[wr_ptr] <= look_ctr[1];
        end
    end

    // Queue pointers and count; pointers wrap naturally (DEPTH is 2**PTR_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            pred_valid <= accept;
            if (accept) pred_taken <= look_ctr[1];
            mispredict <= pop && (res_taken != head_pred);
        end
    end

endmodule

// File: tb/tb_bpred_ctrl.sv
module tb_bpred_ctrl;

    localparam int IDX_W   = 4;
    localparam int DEPTH   = 4;
    localparam int ENTRIES = 1 << IDX_W;

`ifdef BPRED_BYPASS_EN
    localparam logic COLL_EXP = 1'b0;
`else
    localparam logic COLL_EXP = 1'b1;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   req_valid;
    logic [IDX_W-1:0]       req_idx;
    logic                   req_ready;
    logic                   pred_valid;
    logic                   pred_taken;
    logic                   res_valid;
    logic                   res_taken;
    logic                   mispredict;
    logic [$clog2(DEPTH):0] inflight;

    bpred_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .mispredict (mispredict),
        .inflight   (inflight)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    // Outstanding predictions, oldest first: {idx, pred}.
    logic [IDX_W:0] exp_q[$];
    int             mctr [ENTRIES];
    logic           exp_pv;
    logic           exp_pt;
    logic           exp_mis;

    int n_checks;
    int n_errors;

    logic sat_pred [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic sat_mis  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) mctr[i] = 3;
        exp_pv  = 1'b0;
        exp_pt  = 1'b0;
        exp_mis = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model over the coming edge,
    // and returns at posedge+1 with inputs idle.
    task automatic drive_cycle(input logic rv, input logic [IDX_W-1:0] ri,
                               input logic sv, input logic st);
        logic           acc;
        logic           pop;
        logic [IDX_W:0] head;
        int             hidx;
        int             newc;
        int             c;
        req_valid = rv;
        req_idx   = ri;
        res_valid = sv;
        res_taken = st;
        acc  = rv && (exp_q.size() < DEPTH);
        pop  = sv && (exp_q.size() > 0);
        head = '0;
        hidx = 0;
        newc = 0;
        if (pop) begin
            head = exp_q.pop_front();
            hidx = int'(head[IDX_W:1]);
            newc = st ? ((mctr[hidx] < 3) ? mctr[hidx] + 1 : 3)
                      : ((mctr[hidx] > 0) ? mctr[hidx] - 1 : 0);
        end
        exp_mis = pop && (st != head[0]);
        if (acc) begin
            c = mctr[int'(ri)];
`ifdef BPRED_BYPASS_EN
            if (pop && hidx == int'(ri)) c = newc;
`endif
            exp_pt = (c >= 2);
            exp_q.push_back({ri, exp_pt});
        end
        exp_pv = acc;
        if (pop) mctr[hidx] = newc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        res_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_idx   = '0;
        res_valid = 1'b0;
        res_taken = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (pred_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pred_valid got %b want 0", pred_valid); end
        n_checks++;
        if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred_taken got %b want 0", pred_taken); end
        n_checks++;
        if (mispredict !== 1'b0) begin n_errors++; $display("FAIL reset_mispredict got %b want 0", mispredict); end
        n_checks++;
        if (inflight !== 0) begin n_errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, IDX_W'(5), 1'b0, 1'b0);
            n_checks++;
            if (pred_valid !== 1'b1 || pred_taken !== (i < 4 ? sat_pred[i] : 1'b0))
                begin n_errors++; $display("FAIL sat_pred[%0d] got v=%b t=%b want v=1 t=%b", i, pred_valid, pred_taken, (i < 4 ? sat_pred[i] : 1'b0)); end
            n_checks++;
            if (inflight !== 1) begin n_errors++; $display("FAIL sat_inflight[%0d] got %0d want 1", i, inflight); end
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (mispredict !== (i < 4 ? sat_mis[i] : 1'b0))
                begin n_errors++; $display("FAIL sat_mis[%0d] got %b want %b", i, mispredict, (i < 4 ? sat_mis[i] : 1'b0)); end
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            n_checks++;
            if (mispredict !== 1'b0 || inflight !== 0)
                begin n_errors++; $display("FAIL sat_pulse[%0d] got mis=%b inf=%0d want 0 0", i, mispredict, inflight); end
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b1, IDX_W'($urandom_range(0, ENTRIES - 1)), 1'b0, 1'b0);
            n_checks++;
            if (inflight !== i || pred_valid !== 1'b1 || pred_taken !== exp_pt)
                begin n_errors++; $display("FAIL full_fill[%0d] got inf=%0d v=%b t=%b want %0d 1 %b", i, inflight, pred_valid, pred_taken, i, exp_pt); end
        end
        n_checks++;
        if (req_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready got %b want 0", req_ready); end
        drive_cycle(1'b1, IDX_W'(9), 1'b0, 1'b0);
        n_checks++;
        if (pred_valid !== 1'b0 || inflight !== DEPTH)
            begin n_errors++; $display("FAIL full_reject got v=%b inf=%0d want 0 %0d", pred_valid, inflight, DEPTH); end
        drive_cycle(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
        n_checks++;
        if (req_ready !== 1'b1 || inflight !== DEPTH - 1 || mispredict !== exp_mis)
            begin n_errors++; $display("FAIL full_release got rdy=%b inf=%0d mis=%b want 1 %0d %b", req_ready, inflight, mispredict, DEPTH - 1, exp_mis); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
            n_checks++;
            if (mispredict !== exp_mis) begin n_errors++; $display("FAIL full_drain_mis[%0d] got %b want %b", i, mispredict, exp_mis); end
        end
    endtask

    task automatic test_collision();
        drive_cycle(1'b1, IDX_W'(2), 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);          // counter 2: 3 -> 2
        drive_cycle(1'b1, IDX_W'(2), 1'b0, 1'b0);   // outstanding pred 1
        drive_cycle(1'b1, IDX_W'(2), 1'b1, 1'b0);   // resolve NT + lookup same idx
        n_checks++;
        if (pred_valid !== 1'b1 || pred_taken !== COLL_EXP)
            begin n_errors++; $display("FAIL coll_pred got v=%b t=%b want 1 %b", pred_valid, pred_taken, COLL_EXP); end
        n_checks++;
        if (mispredict !== 1'b1 || inflight !== 1)
            begin n_errors++; $display("FAIL coll_mis got mis=%b inf=%0d want 1 1", mispredict, inflight); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);          // counter 2: 1 -> 2
        drive_cycle(1'b1, IDX_W'(2), 1'b0, 1'b0);
        n_checks++;
        if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL coll_final got %b want 1", pred_taken); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_idle_resolve();
        drive_cycle(1'b1, IDX_W'(7), 1'b1, 1'b0);
        n_checks++;
        if (mispredict !== 1'b0 || inflight !== 1 || pred_valid !== 1'b1 || pred_taken !== 1'b1)
            begin n_errors++; $display("FAIL idle_res got mis=%b inf=%0d v=%b t=%b want 0 1 1 1", mispredict, inflight, pred_valid, pred_taken); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b1, IDX_W'(7), 1'b0, 1'b0);   // counter still 3
        n_checks++;
        if (pred_taken !== exp_pt) begin n_errors++; $display("FAIL idle_after got %b want %b", pred_taken, exp_pt); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), IDX_W'($urandom_range(0, ENTRIES - 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (pred_valid !== exp_pv || pred_taken !== exp_pt || mispredict !== exp_mis ||
                inflight !== exp_q.size() || req_ready !== (exp_q.size() < DEPTH))
                begin
                    n_errors++;
                    $display("FAIL rand[%0d] got v=%b t=%b mis=%b inf=%0d rdy=%b want %b %b %b %0d %b",
                             i, pred_valid, pred_taken, mispredict, inflight, req_ready,
                             exp_pv, exp_pt, exp_mis, exp_q.size(), exp_q.size() < DEPTH);
                end
        end
        while (exp_q.size() > 0) drive_cycle(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, IDX_W'($urandom_range(0, ENTRIES - 1)), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (inflight !== 0 || pred_valid !== 1'b0 || mispredict !== 1'b0 || req_ready !== 1'b1 || pred_taken !== 1'b0)
            begin n_errors++; $display("FAIL arst got inf=%0d v=%b mis=%b rdy=%b t=%b want 0 0 0 1 0", inflight, pred_valid, mispredict, req_ready, pred_taken); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, IDX_W'($urandom_range(0, ENTRIES - 1)), 1'b0, 1'b0);
        n_checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || inflight !== 1)
            begin n_errors++; $display("FAIL arst_lookup got v=%b t=%b inf=%0d want 1 1 1", pred_valid, pred_taken, inflight); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_saturation();
        test_full();
        test_collision();
        test_idle_resolve();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
